// File: rtl/enet_if_sel.sv
// ---------------------------------------------------------------------------
// enet_if_sel
//   Frame-aware channel selector for the ENET MAC data path. Forwards one of
//   N_CH PHY-side streams (d/en/er) and changes channel only between frames.
//   A switch drains the current frame, then holds the output idle for
//   GAP_CYC cycles, then waits for an idle cycle on the new channel so that
//   forwarding always starts at a clean frame boundary.
//
// Ports
//   clk, rst_n       : rising-edge clock, asynchronous active-low reset
//   sel_valid/sel_ch : switch request (accepted when sel_ready is high)
//   sel_ready        : high while the selector is forwarding (RUN)
//   sel_err          : one-cycle pulse for an accepted out-of-range channel
//   in_d/in_en/in_er : packed channel inputs, channel i at [i*DATA_W +: DATA_W]
//   out_d/out_en/out_er : selected stream after PIPE_LV register stages
//   cur_ch           : channel currently selected by the mux
//   busy             : switch in progress
// ---------------------------------------------------------------------------
module enet_if_sel #(
  parameter int N_CH    = 4,
  parameter int DATA_W  = 8,
  parameter int CH_W    = 2,
  parameter int GAP_CYC = 12,
  parameter int PIPE_LV = 2,
  parameter int RST_CH  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     sel_valid,
  input  logic [CH_W-1:0]          sel_ch,
  output logic                     sel_ready,
  output logic                     sel_err,
  input  logic [N_CH*DATA_W-1:0]   in_d,
  input  logic [N_CH-1:0]          in_en,
  input  logic [N_CH-1:0]          in_er,
  output logic [DATA_W-1:0]        out_d,
  output logic                     out_en,
  output logic                     out_er,
  output logic [CH_W-1:0]          cur_ch,
  output logic                     busy
);

  // The gap counter only ever holds GAP_CYC-1 down to 0.
  localparam int GC_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int PW   = DATA_W + 2;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_GAP   = 2'd2,
    ST_ALIGN = 2'd3
  } state_t;

  state_t            state_r;
  logic [CH_W-1:0]   cur_ch_r;
  logic [CH_W-1:0]   pend_ch_r;
  logic [GC_W-1:0]   gap_cnt_r;
  logic              sel_err_r;
  logic [PW-1:0]     pipe_r [PIPE_LV];

  logic [DATA_W-1:0] ch_d_s;
  logic              ch_en_s;
  logic              ch_er_s;
  logic              fwd_s;
  logic [PW-1:0]     mux_s;
  logic              sel_bad_s;

  // Pick the stream of cur_ch; an AND-OR select keeps this safe for any
  // index width, including indices that do not map to a channel.
  always_comb begin
    ch_d_s  = {DATA_W{1'b0}};
    ch_en_s = 1'b0;
    ch_er_s = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      ch_d_s  = ch_d_s  | (in_d[i*DATA_W +: DATA_W] & {DATA_W{cur_ch_r == CH_W'(i)}});
      ch_en_s = ch_en_s | (in_en[i] & (cur_ch_r == CH_W'(i)));
      ch_er_s = ch_er_s | (in_er[i] & (cur_ch_r == CH_W'(i)));
    end
  end

  // Forward the selected channel in RUN/DRAIN, force idle in GAP/ALIGN.
  always_comb begin
    fwd_s = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    if (fwd_s) begin
      mux_s = {ch_d_s, ch_en_s, ch_er_s};
    end else begin
      mux_s = {PW{1'b0}};
    end
  end

  assign sel_bad_s = ({1'b0, sel_ch} >= (CH_W+1)'(N_CH));
  assign sel_ready = (state_r == ST_RUN);
  assign busy      = (state_r != ST_RUN);

  // Switch sequencer: RUN -> DRAIN -> GAP -> ALIGN -> RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_RUN;
      cur_ch_r  <= CH_W'(RST_CH);
      pend_ch_r <= {CH_W{1'b0}};
      gap_cnt_r <= {GC_W{1'b0}};
      sel_err_r <= 1'b0;
    end else begin
      sel_err_r <= 1'b0;
      case (state_r)
        ST_RUN: begin
          if (sel_valid) begin
            if (sel_bad_s) begin
              sel_err_r <= 1'b1;
            end else if (sel_ch != cur_ch_r) begin
              pend_ch_r <= sel_ch;
              state_r   <= ST_DRAIN;
            end else begin
              state_r   <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN: begin
          // Leave only once the in-flight frame on cur_ch has ended.
          if (!ch_en_s) begin
            if (GAP_CYC > 0) begin
              gap_cnt_r <= GC_W'(GAP_CYC - 1);
              state_r   <= ST_GAP;
            end else begin
              cur_ch_r  <= pend_ch_r;
              state_r   <= ST_ALIGN;
            end
          end else begin
            state_r <= ST_DRAIN;
          end
        end
        ST_GAP: begin
          if (gap_cnt_r != {GC_W{1'b0}}) begin
            gap_cnt_r <= gap_cnt_r - GC_W'(1);
          end else begin
            cur_ch_r  <= pend_ch_r;
            state_r   <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          // A frame already running on the new channel is skipped whole.
          if (!ch_en_s) begin
            state_r <= ST_RUN;
          end else begin
            state_r <= ST_ALIGN;
          end
        end
        default: begin
          state_r <= ST_RUN;
        end
      endcase
    end
  end

  // Output register pipeline; stage 0 captures the mux.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_LV; k++) begin
        pipe_r[k] <= {PW{1'b0}};
      end
    end else begin
      pipe_r[0] <= mux_s;
      for (int k = 1; k < PIPE_LV; k++) begin
        pipe_r[k] <= pipe_r[k-1];
      end
    end
  end

  assign out_d   = pipe_r[PIPE_LV-1][PW-1:2];
  assign out_en  = pipe_r[PIPE_LV-1][1];
  assign out_er  = pipe_r[PIPE_LV-1][0];
  assign cur_ch  = cur_ch_r;
  assign sel_err = sel_err_r;

endmodule

// File: tb/tb_enet_if_sel.sv
// ---------------------------------------------------------------------------
// tb_enet_if_sel
//   Self-checking bench for enet_if_sel. The main instance uses the default
//   parameters; a second instance (N_CH=3, GAP_CYC=0, PIPE_LV=1) covers the
//   out-of-range request and the zero-gap switch.
// ---------------------------------------------------------------------------
module tb_enet_if_sel;

  localparam int PIPE_LV = 2;
  localparam int GAP_CYC = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // Main instance
  logic        sel_valid, sel_ready, sel_err, out_en, out_er, busy;
  logic [1:0]  sel_ch, cur_ch;
  logic [31:0] in_d;
  logic [3:0]  in_en, in_er;
  logic [7:0]  out_d;

  // Small instance
  logic        sel_valid3, sel_ready3, sel_err3, out_en3, out_er3, busy3;
  logic [1:0]  sel_ch3, cur_ch3;
  logic [23:0] in_d3;
  logic [2:0]  in_en3, in_er3;
  logic [7:0]  out_d3;

  enet_if_sel #(.N_CH(4), .DATA_W(8), .CH_W(2), .GAP_CYC(GAP_CYC),
                .PIPE_LV(PIPE_LV), .RST_CH(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid), .sel_ch(sel_ch),
    .sel_ready(sel_ready), .sel_err(sel_err), .in_d(in_d), .in_en(in_en),
    .in_er(in_er), .out_d(out_d), .out_en(out_en), .out_er(out_er),
    .cur_ch(cur_ch), .busy(busy));

  enet_if_sel #(.N_CH(3), .DATA_W(8), .CH_W(2), .GAP_CYC(0),
                .PIPE_LV(1), .RST_CH(0)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .sel_valid(sel_valid3), .sel_ch(sel_ch3),
    .sel_ready(sel_ready3), .sel_err(sel_err3), .in_d(in_d3), .in_en(in_en3),
    .in_er(in_er3), .out_d(out_d3), .out_en(out_en3), .out_er(out_er3),
    .cur_ch(cur_ch3), .busy(busy3));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: a switch is a pending target, a number of idle cycles
  // still owed, and a "waiting for a frame boundary" flag on each side.
  // -------------------------------------------------------------------------
  int         m_cur, m_pend, m_idle;
  bit         m_drain, m_align, m_err;
  logic [9:0] m_q [$];
  logic [9:0] m_out;

  function automatic bit m_ready();
    return (m_pend < 0) && !m_align;
  endfunction

  task automatic model_reset();
    m_cur = 0; m_pend = -1; m_idle = 0;
    m_drain = 0; m_align = 0; m_err = 0;
    m_q.delete();
    for (int k = 0; k < PIPE_LV - 1; k++) m_q.push_back(10'd0);
  endtask

  task automatic model_step();
    bit fwd;
    bit nerr;
    fwd  = (m_idle == 0) && !m_align;
    nerr = 0;
    if (fwd) m_q.push_back({in_d[m_cur*8 +: 8], in_en[m_cur], in_er[m_cur]});
    else     m_q.push_back(10'd0);
    m_out = m_q.pop_front();
    if (m_ready()) begin
      if (sel_valid) begin
        if (int'(sel_ch) >= 4) nerr = 1;
        else if (int'(sel_ch) != m_cur) begin m_pend = int'(sel_ch); m_drain = 1; end
      end
    end else if (m_drain) begin
      if (!in_en[m_cur]) begin
        m_drain = 0;
        if (GAP_CYC > 0) m_idle = GAP_CYC;
        else begin m_cur = m_pend; m_pend = -1; m_align = 1; end
      end
    end else if (m_idle > 0) begin
      m_idle--;
      if (m_idle == 0) begin m_cur = m_pend; m_pend = -1; m_align = 1; end
    end else if (m_align) begin
      if (!in_en[m_cur]) m_align = 0;
    end
    m_err = nerr;
  endtask

  // One clock: advance the model, let the edge pass, compare everything.
  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check("model", {17'd0, out_d, out_en, out_er, cur_ch, busy, sel_ready, sel_err},
          {17'd0, m_out, 2'(m_cur), !m_ready(), m_ready(), m_err});
  endtask

  // -------------------------------------------------------------------------
  // Table for the idle switch 0 -> 2 (request at row 2). Each row's
  // expectation is the state just after that row's clock edge.
  // -------------------------------------------------------------------------
  typedef struct packed {
    logic       v;
    logic [1:0] ch;
    logic [3:0] en;
    logic       b;
    logic [1:0] c;
    logic       oe;
    logic [7:0] od;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(logic v, logic [1:0] ch, logic [3:0] en, logic b,
                              logic [1:0] c, logic oe, logic [7:0] od);
    vec_t r;
    r.v = v; r.ch = ch; r.en = en; r.b = b; r.c = c; r.oe = oe; r.od = od;
    return r;
  endfunction

  task automatic switch_to(input logic [1:0] ch);
    sel_valid = 1'b1; sel_ch = ch;
    cycle();
    sel_valid = 1'b0;
    repeat (20) cycle();
    check("switch_to_cur", cur_ch, ch);
  endtask

  initial begin
    int got, busy_cnt, got3, bad3;
    logic [7:0] nxt;
    int flen [4];

    tbl[0] = mk(1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 1'b0, 8'h55);
    tbl[1] = mk(1'b0, 2'd0, 4'b0001, 1'b0, 2'd0, 1'b1, 8'h55);
    tbl[2] = mk(1'b1, 2'd2, 4'b0000, 1'b1, 2'd0, 1'b1, 8'h55);
    tbl[3] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 1'b0, 8'h55);
    tbl[4] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 1'b0, 8'h55);
    for (int r = 5; r <= 14; r++) tbl[r] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 2'd0, 1'b0, 8'h00);
    tbl[15] = mk(1'b0, 2'd0, 4'b0000, 1'b1, 2'd2, 1'b0, 8'h00);
    tbl[16] = mk(1'b0, 2'd0, 4'b0000, 1'b0, 2'd2, 1'b0, 8'h00);
    tbl[17] = mk(1'b0, 2'd0, 4'b0100, 1'b0, 2'd2, 1'b0, 8'h00);
    tbl[18] = mk(1'b0, 2'd0, 4'b0100, 1'b0, 2'd2, 1'b1, 8'h77);

    sel_valid = 1'b0; sel_ch = 2'd0;
    in_d = 32'h88776655; in_en = 4'b0001; in_er = 4'b0000;
    sel_valid3 = 1'b0; sel_ch3 = 2'd0;
    in_d3 = 24'h332211; in_en3 = 3'b000; in_er3 = 3'b000;
    model_reset();

    // Reset state
    #23;
    check("rst_out_d", out_d, 8'h00);
    check("rst_out_en", out_en, 1'b0);
    check("rst_cur_ch", cur_ch, 2'd0);
    check("rst_sel_ready", sel_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    // ch0 0x55 with en appears two cycles later
    cycle();
    check("lat_cyc1_en", out_en, 1'b0);
    cycle();
    check("lat_cyc2_d", out_d, 8'h55);
    check("lat_cyc2_en", out_en, 1'b1);
    in_en = 4'b0000;
    repeat (3) cycle();

    // Table-driven idle switch
    for (int r = 0; r < 19; r++) begin
      sel_valid = tbl[r].v; sel_ch = tbl[r].ch; in_en = tbl[r].en;
      cycle();
      check($sformatf("tbl%0d", r), {busy, cur_ch, out_en, out_d},
            {tbl[r].b, tbl[r].c, tbl[r].oe, tbl[r].od});
    end
    sel_valid = 1'b0; in_en = 4'b0000;
    switch_to(2'd0);

    // Mid-frame switch: the 40-byte frame on ch0 must come out whole
    got = 0; busy_cnt = 0; nxt = 8'd0;
    for (int k = 0; k < 65; k++) begin
      in_en = (k < 40) ? 4'b0001 : 4'b0000;
      in_d[7:0] = 8'(k);
      sel_valid = (k == 5); sel_ch = 2'd1;
      cycle();
      if (out_en && out_d == nxt) begin got++; nxt++; end
      if (k >= 5 && k <= 52 && busy) busy_cnt++;
    end
    sel_valid = 1'b0;
    check("midframe_bytes", got, 40);
    check("midframe_busy", busy_cnt, 48);
    check("midframe_cur", cur_ch, 2'd1);

    // Frame on ch3 already running at ALIGN entry is dropped; next one kept
    got3 = 0; bad3 = 0;
    for (int k = 0; k < 65; k++) begin
      sel_valid = (k == 0); sel_ch = 2'd3;
      in_en = 4'b0000;
      in_en[3] = ((k >= 5) && (k < 35)) || ((k >= 37) && (k < 47));
      in_d[31:24] = (k < 35) ? 8'(8'h30 + k) : 8'(8'hC0 + k);
      cycle();
      if (out_en) begin
        if (out_d >= 8'hC0) got3++;
        else bad3++;
      end
    end
    sel_valid = 1'b0; in_en = 4'b0000;
    check("align_next_frame", got3, 10);
    check("align_dropped", bad3, 0);

    // Asynchronous reset in the middle of the gap
    sel_valid = 1'b1; sel_ch = 2'd0;
    cycle();
    sel_valid = 1'b0;
    repeat (5) cycle();
    check("gap_busy_pre", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_cur", cur_ch, 2'd0);
    check("arst_busy", busy, 1'b0);
    check("arst_out", {out_d, out_en, out_er}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Small instance: invalid, no-op, zero-gap switch
    sel_valid3 = 1'b1; sel_ch3 = 2'd3;
    cycle();
    sel_valid3 = 1'b0;
    check("inv_err", sel_err3, 1'b1);
    check("inv_cur", cur_ch3, 2'd0);
    check("inv_busy", busy3, 1'b0);
    cycle();
    check("inv_err_pulse", sel_err3, 1'b0);
    sel_valid3 = 1'b1; sel_ch3 = 2'd0;
    cycle();
    sel_valid3 = 1'b0;
    check("noop_err_busy", {sel_err3, busy3}, 2'b00);
    sel_valid3 = 1'b1; sel_ch3 = 2'd2;
    cycle();
    sel_valid3 = 1'b0;
    check("g0_drain", {busy3, cur_ch3}, {1'b1, 2'd0});
    cycle();
    check("g0_align", {busy3, cur_ch3}, {1'b1, 2'd2});
    check("g0_align_idle", out_en3, 1'b0);
    cycle();
    check("g0_run", {busy3, cur_ch3}, {1'b0, 2'd2});
    in_en3 = 3'b100;
    cycle();
    check("g0_data", {out_d3, out_en3, out_er3}, {8'h33, 1'b1, 1'b0});
    in_en3 = 3'b000;

    // Random traffic against the model
    for (int i = 0; i < 4; i++) flen[i] = 0;
    for (int n = 0; n < 2500; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (flen[i] > 0) begin
          in_en[i] = 1'b1;
          in_d[i*8 +: 8] = 8'($urandom);
          in_er[i] = ($urandom_range(0, 15) == 0);
          flen[i]--;
        end else begin
          in_en[i] = 1'b0;
          in_er[i] = ($urandom_range(0, 31) == 0);
          if ($urandom_range(0, 5) == 0) flen[i] = $urandom_range(1, 24);
        end
      end
      if (!(sel_valid && !m_ready())) begin
        sel_valid = ($urandom_range(0, 19) == 0);
        sel_ch = 2'($urandom_range(0, 3));
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/enet_if_sel.md
Name: enet_if_sel

Overview:
- Single-clock, frame-aware channel selector for the ENET MAC data path.
- Forwards one of N_CH PHY-side data streams (d/en/er) to one output and switches channels only at frame boundaries.
- Between frames it inserts a forced-idle gap, then re-aligns to a clean frame start on the new channel.
- Successor to the fixed 4-way interface mux: parametrised channel count and width, with a handshaked runtime switch request, drain/gap/align sequencing and a registered output pipeline.

Parameters:
- N_CH, 4: number of input channels (>=2).
- DATA_W, 8: data width per channel.
- CH_W, 2: width of channel index; must be >= clog2(N_CH).
- GAP_CYC, 12: forced-idle cycles inserted on a switch (0 allowed).
- PIPE_LV, 2: output register stages (>=1).
- RST_CH, 0: channel selected out of reset (< N_CH).

Ports:
- clk, in, 1: block clock; all logic is on the rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- sel_valid, in, 1: switch request valid.
- sel_ch, in, CH_W: requested channel.
- sel_ready, out, 1: request accepted when sel_valid && sel_ready.
- sel_err, out, 1: one-cycle pulse for an accepted request with sel_ch >= N_CH.
- in_d, in, N_CH*DATA_W: channel data; channel i occupies bits [i*DATA_W +: DATA_W].
- in_en, in, N_CH: per-channel frame enable.
- in_er, in, N_CH: per-channel error.
- out_d, out, DATA_W: selected data.
- out_en, out, 1: selected enable.
- out_er, out, 1: selected error.
- cur_ch, out, CH_W: currently forwarded channel.
- busy, out, 1: switch in progress (state != RUN).

Behaviour:
- Reset values:
  - state=RUN, cur_ch=RST_CH, pend_ch=0, gap counter=0.
  - sel_err=0; all pipeline stages 0, so out_d/out_en/out_er=0.
  - Reset asserted mid-switch abandons the switch; no pending request survives.
- sel_ready = (state==RUN), combinational. busy = !sel_ready.
- Mux stage (combinational, feeds pipeline stage 1):
  - RUN and DRAIN: forward in_d/in_en/in_er of cur_ch.
  - GAP and ALIGN: force d=0, en=0, er=0.
- Output pipeline: PIPE_LV stages. Mux value in cycle t appears on the outputs at cycle t+PIPE_LV.
- FSM:
  - RUN, on accept of sel_ch:
    - sel_ch >= N_CH: sel_err=1 next cycle (for exactly one cycle); stay RUN; cur_ch unchanged.
    - sel_ch == cur_ch: no-op; stay RUN; no err.
    - Otherwise: pend_ch <= sel_ch; go to DRAIN.
  - DRAIN: keep forwarding cur_ch.
    - When in_en[cur_ch]==0 is sampled: if GAP_CYC>0, go to GAP with counter <= GAP_CYC-1; if GAP_CYC==0, set cur_ch <= pend_ch and go to ALIGN.
    - The in-flight frame is never truncated.
  - GAP: outputs idle.
    - Counter > 0: decrement.
    - Counter == 0: cur_ch <= pend_ch; go to ALIGN.
    - Exactly GAP_CYC cycles are spent in GAP.
  - ALIGN: outputs idle.
    - in_en[cur_ch]==0 sampled: go to RUN; forwarding starts the next cycle.
    - Otherwise remain in ALIGN. A frame already in progress on the new channel is discarded whole, never forwarded partially.
- sel_valid outside RUN is ignored (ready=0); the requester holds it.
- Channel inputs are assumed synchronous to clk; no synchronisers are inside the block.
- in_er on a non-selected channel has no effect.
- Minimum idle at the mux on a switch = GAP_CYC + 1 (ALIGN) cycles.

Test Plan:
- Reset, defaults (N_CH=4, GAP_CYC=12, PIPE_LV=2, RST_CH=0):
  - During reset: outputs 0, cur_ch=0, sel_ready=1.
  - Drive ch0 in_d=0x55, in_en=1 -> out_d=0x55, out_en=1 two cycles later.
- Switch while idle:
  - Stimulus: ch0 in_en=0; request sel_ch=2 at cycle T; ch2 en=0.
  - Response: DRAIN at T+1, GAP at T+2..T+13, ALIGN at T+14, RUN at T+15.
  - cur_ch=2 from T+14; out_en stays 0 through T+16 (pipeline delay of the last idle mux cycle); ch2 data is visible at T+17.
- Switch mid-frame:
  - Stimulus: ch0 en=1 for 40 cycles; request sel_ch=1 at cycle 5.
  - Response: all 40 bytes of ch0 appear on the output; GAP begins the cycle after ch0 en falls; busy=1 throughout.
- New channel mid-frame at ALIGN:
  - Stimulus: ch3 en=1 for 30 cycles spanning the ALIGN entry.
  - Response: none of that frame is output; ch3's next frame is forwarded in full.
- Invalid and no-op requests:
  - Configure N_CH=3, CH_W=2; sel_ch=3 -> sel_err pulses 1 cycle, cur_ch unchanged, state RUN.
  - sel_ch=cur_ch -> no err, busy stays 0.
- Corner cases:
  - GAP_CYC=0: a switch goes DRAIN->ALIGN->RUN in 2 cycles.
  - Assert rst_n=0 during GAP: state returns to RUN, cur_ch=RST_CH, outputs 0 immediately (asynchronous).
